text_cmd_engine: RTL and testbench

Command sequencer for port A of the 2560x16 character buffer (32-line ring of 80 columns). Accepts terminal-style commands (put char, newline, clear screen, set cursor, read char) over a valid/ready handshake. Generates buffer addresses, write strobes and fill sweeps, and maintains the cursor and ring top-line pointer consumed by the text renderer. Sits between the CPU register interface and character_buffer port A.

---
 rtl/text_cmd_engine.sv | 232 +++++++++++++++++++++++
 tb/tb_text_cmd_engine.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_cmd_engine.sv
// rtl/text_cmd_engine.sv - command sequencer for character buffer port A
// Runs put/newline/clear/cursor/read commands and keeps the cursor and the ring top line.
module text_cmd_engine #(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 30,
  parameter int          BUF_ROWS     = 32,
  parameter logic [15:0] DEFAULT_FILL = 16'h0720
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_we,
  input  logic [15:0] mem_dout,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic [4:0]  top_line,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FILL,
    ST_RD1,
    ST_RD2,
    ST_HOLD
  } state_t;

  localparam logic [2:0]  OP_PUT     = 3'd0;
  localparam logic [2:0]  OP_NEWLINE = 3'd1;
  localparam logic [2:0]  OP_CLEAR   = 3'd2;
  localparam logic [2:0]  OP_SETCUR  = 3'd3;
  localparam logic [2:0]  OP_READ    = 3'd4;
  localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
  localparam logic [4:0]  LAST_PHYS  = 5'(BUF_ROWS - 1);
  localparam logic [11:0] LAST_ADDR  = 12'(COLS * BUF_ROWS - 1);

  function automatic logic [11:0] f_addr(input logic [4:0] top, input logic [4:0] row,
                                         input logic [6:0] col);
    logic [5:0] sum;
    logic [4:0] phys;
    sum  = {1'b0, top} + {1'b0, row};
    phys = (sum >= 6'(BUF_ROWS)) ? 5'(sum - 6'(BUF_ROWS)) : sum[4:0];
    return 12'(phys) * 12'(COLS) + {5'b0, col};
  endfunction

  state_t      r_state, w_state_nxt;
  logic [11:0] r_mem_addr, w_mem_addr_nxt;
  logic [15:0] r_mem_din, w_mem_din_nxt;
  logic        r_mem_we, w_mem_we_nxt;
  logic [15:0] r_rd_data, w_rd_data_nxt;
  logic        r_rd_valid, w_rd_valid_nxt;
  logic [6:0]  r_col, w_col_nxt;
  logic [4:0]  r_row, w_row_nxt;
  logic [4:0]  r_top, w_top_nxt;
  logic [15:0] r_fill_word, w_fill_word_nxt;
  logic [11:0] r_fill_end, w_fill_end_nxt;
  logic        r_fill_clear, w_fill_clear_nxt;

  logic [11:0] w_cur_addr;
  logic [4:0]  w_top_inc;
  logic [11:0] w_scroll_start;
  logic [11:0] w_scroll_end;
  logic [6:0]  w_set_col;
  logic [4:0]  w_set_row;
  logic        w_unused_bits;

  // A scroll clears the line the cursor lands on once top_line has advanced.
  assign w_cur_addr     = f_addr(r_top, r_row, r_col);
  assign w_top_inc      = (r_top == LAST_PHYS) ? 5'd0 : r_top + 5'd1;
  assign w_scroll_start = f_addr(w_top_inc, r_row, 7'd0);
  assign w_scroll_end   = w_scroll_start + 12'(COLS - 1);
  assign w_set_col      = (cmd_data[6:0] > LAST_COL) ? LAST_COL : cmd_data[6:0];
  assign w_set_row      = (cmd_data[12:8] > LAST_ROW) ? LAST_ROW : cmd_data[12:8];
  assign w_unused_bits  = ^{cmd_data[15:13], cmd_data[7]};

  always_comb begin
    w_state_nxt      = r_state;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_din_nxt    = r_mem_din;
    w_mem_we_nxt     = 1'b0;
    w_rd_data_nxt    = r_rd_data;
    w_rd_valid_nxt   = 1'b0;
    w_col_nxt        = r_col;
    w_row_nxt        = r_row;
    w_top_nxt        = r_top;
    w_fill_word_nxt  = r_fill_word;
    w_fill_end_nxt   = r_fill_end;
    w_fill_clear_nxt = r_fill_clear;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PUT: begin
              w_mem_addr_nxt = w_cur_addr;
              w_mem_din_nxt  = cmd_data;
              w_mem_we_nxt   = 1'b1;
              w_state_nxt    = ST_WRITE;
            end
            OP_NEWLINE: begin
              w_col_nxt = 7'd0;
              if (r_row < LAST_ROW) begin
                w_row_nxt   = r_row + 5'd1;
                w_state_nxt = ST_HOLD;
              end else begin
                w_top_nxt        = w_top_inc;
                w_mem_addr_nxt   = w_scroll_start;
                w_mem_din_nxt    = r_fill_word;
                w_mem_we_nxt     = 1'b1;
                w_fill_end_nxt   = w_scroll_end;
                w_fill_clear_nxt = 1'b0;
                w_state_nxt      = ST_FILL;
              end
            end
            OP_CLEAR: begin
              w_fill_word_nxt  = cmd_data;
              w_mem_addr_nxt   = 12'd0;
              w_mem_din_nxt    = cmd_data;
              w_mem_we_nxt     = 1'b1;
              w_fill_end_nxt   = LAST_ADDR;
              w_fill_clear_nxt = 1'b1;
              w_state_nxt      = ST_FILL;
            end
            OP_SETCUR: begin
              w_col_nxt   = w_set_col;
              w_row_nxt   = w_set_row;
              w_state_nxt = ST_HOLD;
            end
            OP_READ: begin
              w_mem_addr_nxt = w_cur_addr;
              w_state_nxt    = ST_RD1;
            end
            default: w_state_nxt = ST_HOLD;
          endcase
        end
      end
      ST_WRITE: begin
        if (r_col < LAST_COL) begin
          w_col_nxt   = r_col + 7'd1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_col_nxt = 7'd0;
          if (r_row < LAST_ROW) begin
            w_row_nxt   = r_row + 5'd1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_top_nxt        = w_top_inc;
            w_mem_addr_nxt   = w_scroll_start;
            w_mem_din_nxt    = r_fill_word;
            w_mem_we_nxt     = 1'b1;
            w_fill_end_nxt   = w_scroll_end;
            w_fill_clear_nxt = 1'b0;
            w_state_nxt      = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (r_mem_addr == r_fill_end) begin
          w_state_nxt = ST_IDLE;
          if (r_fill_clear) begin
            w_col_nxt        = 7'd0;
            w_row_nxt        = 5'd0;
            w_top_nxt        = 5'd0;
            w_fill_clear_nxt = 1'b0;
          end
        end else begin
          w_mem_addr_nxt = r_mem_addr + 12'd1;
          w_mem_we_nxt   = 1'b1;
        end
      end
      ST_RD1: w_state_nxt = ST_RD2;
      ST_RD2: begin
        // mem_dout now reflects the address presented during RD1.
        w_rd_data_nxt  = mem_dout;
        w_rd_valid_nxt = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_mem_addr   <= 12'd0;
      r_mem_din    <= 16'd0;
      r_mem_we     <= 1'b0;
      r_rd_data    <= 16'd0;
      r_rd_valid   <= 1'b0;
      r_col        <= 7'd0;
      r_row        <= 5'd0;
      r_top        <= 5'd0;
      r_fill_word  <= DEFAULT_FILL;
      r_fill_end   <= 12'd0;
      r_fill_clear <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_din    <= w_mem_din_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_rd_data    <= w_rd_data_nxt;
      r_rd_valid   <= w_rd_valid_nxt;
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      r_top        <= w_top_nxt;
      r_fill_word  <= w_fill_word_nxt;
      r_fill_end   <= w_fill_end_nxt;
      r_fill_clear <= w_fill_clear_nxt;
    end
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign busy       = ~cmd_ready;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;
  assign mem_we     = r_mem_we;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign cursor_col = r_col;
  assign cursor_row = r_row;
  assign top_line   = r_top;

endmodule

// File: tb/tb_text_cmd_engine.sv
// tb/tb_text_cmd_engine.sv - self-checking bench for text_cmd_engine
// Directed table, screen-model random run, clear/scroll/reset-abort sequences.
module tb_text_cmd_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [11:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic [15:0] mem_dout = 16'h0000;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [4:0]  top_line;
  logic        busy;

  always #5 clk = ~clk;

  text_cmd_engine dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_we(mem_we), .mem_dout(mem_dout), .rd_data(rd_data), .rd_valid(rd_valid),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .top_line(top_line), .busy(busy)
  );

  // Character RAM with one-cycle registered read, plus a write log.
  logic [15:0] ram [0:2559] = '{default: 16'h0000};
  logic [11:0] wr_hist [0:4095];
  int          wr_total = 0;

  always @(posedge clk) begin
    mem_dout <= (mem_addr < 12'd2560) ? ram[mem_addr] : 16'hDEAD;
    if (mem_we) begin
      if (mem_addr < 12'd2560) ram[mem_addr] <= mem_din;
      wr_hist[wr_total % 4096] <= mem_addr;
      wr_total <= wr_total + 1;
    end
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Screen model: cursor, ring top and expected buffer contents.
  int          m_col, m_row, m_top;
  logic [15:0] m_fill;
  logic [15:0] exp_mem [0:2559] = '{default: 16'h0000};

  function automatic int m_addr(input int r, input int c);
    return ((m_top + r) % 32) * 80 + c;
  endfunction

  task automatic m_newline(output bit scrolled, output int start);
    scrolled = 0;
    start    = -1;
    m_col    = 0;
    if (m_row < 29) m_row++;
    else begin
      m_top    = (m_top + 1) % 32;
      start    = m_addr(m_row, 0);
      scrolled = 1;
      for (int i = 0; i < 80; i++) exp_mem[start + i] = m_fill;
    end
  endtask

  task automatic model_cmd(input logic [2:0] op, input logic [15:0] d, output int busy_n,
                           output int nwr, output int first, output int rdn,
                           output logic [15:0] rdv);
    bit sc;
    int s, a;
    busy_n = 1; nwr = 0; first = -1; rdn = 0; rdv = 16'h0;
    case (op)
      3'd0: begin
        a = m_addr(m_row, m_col);
        exp_mem[a] = d;
        nwr = 1; first = a;
        m_col++;
        if (m_col == 80) begin
          m_newline(sc, s);
          if (sc) begin busy_n += 80; nwr += 80; end
        end
      end
      3'd1: begin
        m_newline(sc, s);
        if (sc) begin busy_n = 80; nwr = 80; first = s; end
      end
      3'd2: begin
        m_fill = d;
        for (int i = 0; i < 2560; i++) exp_mem[i] = d;
        m_col = 0; m_row = 0; m_top = 0;
        busy_n = 2560; nwr = 2560; first = 0;
      end
      3'd3: begin
        m_col = (int'(d[6:0]) > 79) ? 79 : int'(d[6:0]);
        m_row = (int'(d[12:8]) > 29) ? 29 : int'(d[12:8]);
      end
      3'd4: begin
        busy_n = 2; rdn = 1;
        rdv = exp_mem[m_addr(m_row, m_col)];
      end
      default: ;
    endcase
  endtask

  // Issue one command from a negedge and observe it until idle plus one cycle.
  task automatic run_cmd(input logic [2:0] op, input logic [15:0] d, output int busy_n,
                         output int nwr, output int first, output int rdn,
                         output logic [15:0] rdv, output bit tmo);
    int n, base;
    tmo = 0; n = 0;
    while (cmd_ready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) tmo = 1;
    base = wr_total;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_data = 16'($urandom);
    busy_n = 0; rdn = 0; rdv = 16'h0;
    @(negedge clk);
    while (cmd_ready !== 1'b1) begin
      busy_n++;
      if (rd_valid) rdn++;
      if (busy_n > 3000) begin tmo = 1; break; end
      @(negedge clk);
    end
    if (rd_valid) begin rdn++; rdv = rd_data; end
    @(negedge clk);
    if (rd_valid) rdn++;
    nwr   = wr_total - base;
    first = (nwr > 0) ? int'(wr_hist[base % 4096]) : -1;
  endtask

  task automatic do_cmd(input string name, input logic [2:0] op, input logic [15:0] d);
    int eb, ew, ef, er, ab, aw, af, ar;
    logic [15:0] ev, av;
    bit tmo;
    model_cmd(op, d, eb, ew, ef, er, ev);
    run_cmd(op, d, ab, aw, af, ar, av, tmo);
    chk({name, ".timeout"}, int'(tmo), 0);
    chk({name, ".busy"}, ab, eb);
    chk({name, ".writes"}, aw, ew);
    if (ew > 0) chk({name, ".first_addr"}, af, ef);
    chk({name, ".rd_pulses"}, ar, er);
    if (er > 0) chk({name, ".rd_data"}, int'(av), int'(ev));
    chk({name, ".col"}, int'(cursor_col), m_col);
    chk({name, ".row"}, int'(cursor_row), m_row);
    chk({name, ".top"}, int'(top_line), m_top);
  endtask

  task automatic img_check(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 2560; i++) if (ram[i] !== exp_mem[i]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, ".ready"}, int'(cmd_ready), 1);
    chk({name, ".busy"}, int'(busy), 0);
    chk({name, ".we"}, int'(mem_we), 0);
    chk({name, ".addr"}, int'(mem_addr), 0);
    chk({name, ".din"}, int'(mem_din), 0);
    chk({name, ".rd"}, int'({rd_valid, rd_data}), 0);
    chk({name, ".cursor"}, int'({cursor_row, cursor_col}), 0);
    chk({name, ".top"}, int'(top_line), 0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] data;
    int          col, row, top, busy_n, nwr, first, rdn;
    logic [15:0] rdv;
  } vec_t;

  vec_t tbl [20];

  initial begin
    int eb, ew, ef, er, ab, aw, af, ar, n, base;
    logic [15:0] ev, av, d;
    bit tmo;
    int r;

    //           op    data      col row top busy wr  first rdn rdv
    tbl[0]  = '{3'd0, 16'h1F41, 1,  0,  0,  1,   1,  0,    0, 16'h0};
    tbl[1]  = '{3'd3, 16'h054F, 79, 5,  0,  1,   0,  -1,   0, 16'h0};
    tbl[2]  = '{3'd0, 16'h0742, 0,  6,  0,  1,   1,  479,  0, 16'h0};
    tbl[3]  = '{3'd3, 16'h1D00, 0,  29, 0,  1,   0,  -1,   0, 16'h0};
    tbl[4]  = '{3'd1, 16'h0000, 0,  29, 1,  80,  80, 2400, 0, 16'h0};
    tbl[5]  = '{3'd3, 16'h0203, 3,  2,  1,  1,   0,  -1,   0, 16'h0};
    tbl[6]  = '{3'd0, 16'h0C58, 4,  2,  1,  1,   1,  243,  0, 16'h0};
    tbl[7]  = '{3'd3, 16'h0203, 3,  2,  1,  1,   0,  -1,   0, 16'h0};
    tbl[8]  = '{3'd4, 16'h0000, 3,  2,  1,  2,   0,  -1,   1, 16'h0C58};
    tbl[9]  = '{3'd3, 16'h1F7F, 79, 29, 1,  1,   0,  -1,   0, 16'h0};
    tbl[10] = '{3'd5, 16'hFFFF, 79, 29, 1,  1,   0,  -1,   0, 16'h0};
    tbl[11] = '{3'd1, 16'h0000, 0,  29, 2,  80,  80, 2480, 0, 16'h0};
    tbl[12] = '{3'd3, 16'h1D4F, 79, 29, 2,  1,   0,  -1,   0, 16'h0};
    tbl[13] = '{3'd0, 16'h0741, 0,  29, 3,  81,  81, 2559, 0, 16'h0};
    tbl[14] = '{3'd1, 16'h0000, 0,  29, 4,  80,  80, 80,   0, 16'h0};
    tbl[15] = '{3'd4, 16'h0000, 0,  29, 4,  2,   0,  -1,   1, 16'h0720};
    tbl[16] = '{3'd3, 16'h0000, 0,  0,  4,  1,   0,  -1,   0, 16'h0};
    tbl[17] = '{3'd1, 16'h0000, 0,  1,  4,  1,   0,  -1,   0, 16'h0};
    tbl[18] = '{3'd7, 16'h1234, 0,  1,  4,  1,   0,  -1,   0, 16'h0};
    tbl[19] = '{3'd0, 16'h4E4F, 1,  1,  4,  1,   1,  400,  0, 16'h0};

    m_col = 0; m_row = 0; m_top = 0; m_fill = 16'h0720;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 16'h0;
    repeat (3) @(negedge clk);
    chk_reset_outs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      model_cmd(tbl[i].op, tbl[i].data, eb, ew, ef, er, ev);
      run_cmd(tbl[i].op, tbl[i].data, ab, aw, af, ar, av, tmo);
      chk($sformatf("tbl%0d.timeout", i), int'(tmo), 0);
      chk($sformatf("tbl%0d.busy", i), ab, tbl[i].busy_n);
      chk($sformatf("tbl%0d.writes", i), aw, tbl[i].nwr);
      if (tbl[i].nwr > 0) chk($sformatf("tbl%0d.first_addr", i), af, tbl[i].first);
      chk($sformatf("tbl%0d.rd_pulses", i), ar, tbl[i].rdn);
      if (tbl[i].rdn > 0) chk($sformatf("tbl%0d.rd_data", i), int'(av), int'(tbl[i].rdv));
      chk($sformatf("tbl%0d.cursor", i), int'({cursor_row, cursor_col}),
          (tbl[i].row << 7) | tbl[i].col);
      chk($sformatf("tbl%0d.top", i), int'(top_line), tbl[i].top);
    end
    img_check("tbl.image");

    do_cmd("clear", 3'd2, 16'h1E20);
    chk("clear.last_word", int'(ram[2559]), 16'h1E20);
    img_check("clear.image");
    do_cmd("scroll.set", 3'd3, 16'h1D00);
    for (int i = 0; i < 32; i++) begin
      do_cmd($sformatf("scroll%0d", i), 3'd1, 16'h0000);
      chk($sformatf("scroll%0d.top_seq", i), int'(top_line), (i + 1) % 32);
    end
    img_check("scroll.image");

    for (int i = 0; i < 160; i++) begin
      r = $urandom_range(0, 99);
      d = 16'($urandom);
      if (r < 40)      do_cmd($sformatf("rnd%0d.put", i), 3'd0, d);
      else if (r < 50) do_cmd($sformatf("rnd%0d.nl", i), 3'd1, d);
      else if (r < 52) do_cmd($sformatf("rnd%0d.clr", i), 3'd2, d);
      else if (r < 75) begin
        if ($urandom_range(0, 1) == 1) d[12:8] = 5'd29;
        do_cmd($sformatf("rnd%0d.set", i), 3'd3, d);
      end
      else if (r < 90) do_cmd($sformatf("rnd%0d.rd", i), 3'd4, d);
      else             do_cmd($sformatf("rnd%0d.nop", i), 3'($urandom_range(5, 7)), d);
      if (i % 40 == 39) img_check($sformatf("rnd%0d.image", i));
    end

    do_cmd("abort.set", 3'd3, 16'h0A0A);
    base = wr_total;
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_data = 16'h5A5A;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 0;
    while (wr_total - base < 1000 && n < 3000) begin @(negedge clk); n++; end
    chk("abort.reach_1000", wr_total - base, 1000);
    reset_n = 1'b0;
    #1;
    chk_reset_outs("abort");
    repeat (2) @(negedge clk);
    chk("abort.no_writes_in_reset", wr_total - base, 1000);
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort.ready_after", int'(cmd_ready), 1);
    for (int i = 0; i < 1000; i++) exp_mem[i] = 16'h5A5A;
    m_col = 0; m_row = 0; m_top = 0; m_fill = 16'h0720;
    img_check("abort.image");
    do_cmd("abort.set2", 3'd3, 16'h1D00);
    do_cmd("abort.scroll", 3'd1, 16'h0000);
    img_check("final.image");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
